// File: rtl/mfp_uart_tx.sv
// mfp_uart_tx - byte-oriented UART transmitter with transmit FIFO.
//
// Bytes arrive over a valid/ready handshake, are buffered in a circular
// FIFO and are sent LSB first as 8N1 frames (8E1 when
// MFP_UART_TX_PARITY_EN is defined) on a registered, idle-high line.
//
// Parameters:
//   CLK_FREQ_HZ  clock frequency in Hz
//   BAUD         line rate in bits/s
//   FIFO_DEPTH   FIFO entries, power of two, >= 2
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   tx_data      byte to transmit
//   tx_valid     tx_data is valid this cycle
//   tx_ready     FIFO can accept a byte
//   tx_busy      frame on the line or FIFO non-empty
//   fifo_count   bytes buffered, excluding the frame in flight
//   UART_TX      serial output, idle high
//
// Build option: MFP_UART_TX_PARITY_EN adds an even-parity bit after bit 7.

module mfp_uart_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          UART_TX
);

  // state  | meaning
  // IDLE   | line high, waiting for a buffered byte
  // START  | start bit (low)
  // DATA   | data bits, LSB first
  // PARITY | even parity bit (parity build only)
  // STOP   | stop bit (high); chains straight into START if data waits

  localparam int DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_TICK = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("mfp_uart_tx: clocks per bit must be at least 2");
  end

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("mfp_uart_tx: FIFO_DEPTH must be a power of two and at least 2");
  end

`ifdef MFP_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [CW-1:0] baud_cnt;
`ifdef MFP_UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic          bit_end;

  assign fifo_nonempty = (fifo_count != '0);
  assign bit_end       = (baud_cnt == LAST_TICK);
  assign tx_ready      = (fifo_count != FULL_CNT);
  assign push          = tx_valid && tx_ready;
  // The FSM takes the head either from IDLE or at the last STOP cycle.
  assign pop           = fifo_nonempty &&
                         ((state == IDLE) || ((state == STOP) && bit_end));
  assign tx_busy       = (state != IDLE) || fifo_nonempty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // UART_TX is assigned alongside each transition so the line carries the
  // new bit from the first cycle of the new state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      baud_cnt   <= '0;
      UART_TX    <= 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          UART_TX <= 1'b1;
          if (fifo_nonempty) begin
            shift      <= mem[rd_ptr];
`ifdef MFP_UART_TX_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
            bit_idx    <= '0;
            baud_cnt   <= '0;
            UART_TX    <= 1'b0;
            state      <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            UART_TX  <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
              UART_TX <= parity_bit;
              state   <= PARITY;
`else
              UART_TX <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              UART_TX <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef MFP_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            UART_TX  <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (fifo_nonempty) begin
              shift      <= mem[rd_ptr];
`ifdef MFP_UART_TX_PARITY_EN
              parity_bit <= ^mem[rd_ptr];
`endif
              bit_idx    <= '0;
              UART_TX    <= 1'b0;
              state      <= START;
            end else begin
              UART_TX <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          UART_TX <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
